// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - PC register, instruction-memory requester and decoder handoff with redirect handling
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ack,
    input  logic [31:0] im_rdata,
    output logic [31:0] instruction,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [1:0]  pc_mux_sel,
    input  logic        branch_taken,
    input  logic [31:0] ctl_pc,
    input  logic [15:0] imm,
    input  logic [25:0] jump_index
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_DROP = 2'd3;

    logic [1:0]  state;
    logic [31:0] fetch_pc;
    logic [31:0] pend_pc;
    logic        eff_redirect;
    logic [31:0] ctl_pc_next;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] target;

    // Only jumps and taken branches change the fetch stream; everything else is a no-op pulse.
    always_comb begin
        eff_redirect  = redirect &&
                        ((pc_mux_sel == 2'b10) || ((pc_mux_sel == 2'b01) && branch_taken));
        ctl_pc_next   = ctl_pc + 32'd4;
        branch_target = ctl_pc_next + {{14{imm[15]}}, imm, 2'b00};
        jump_target   = {ctl_pc_next[31:28], jump_index, 2'b00};
        target        = (pc_mux_sel == 2'b10) ? jump_target : branch_target;
    end

    assign im_req     = (state == S_REQ) || (state == S_DROP);
    assign im_addr    = fetch_pc;
    assign inst_valid = (state == S_HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            fetch_pc    <= RESET_PC;
            pend_pc     <= 32'd0;
            instruction <= 32'd0;
            inst_pc     <= 32'd0;
        end else begin
            case (state)
                S_IDLE: state <= S_REQ;
                S_REQ: begin
                    if (im_ack) begin
                        if (eff_redirect) begin
                            fetch_pc <= target;
                        end else begin
                            instruction <= im_rdata;
                            inst_pc     <= fetch_pc;
                            fetch_pc    <= fetch_pc + 32'd4;
                            state       <= S_HOLD;
                        end
                    end else if (eff_redirect) begin
                        pend_pc <= target;
                        state   <= S_DROP;
                    end
                end
                // Wrong-path request stays on the bus until memory completes it.
                S_DROP: begin
                    if (im_ack) begin
                        fetch_pc <= eff_redirect ? target : pend_pc;
                        state    <= S_REQ;
                    end else if (eff_redirect) begin
                        pend_pc <= target;
                    end
                end
                S_HOLD: begin
                    if (eff_redirect) begin
                        fetch_pc <= target;
                        state    <= S_REQ;
                    end else if (inst_ready) begin
                        state <= S_REQ;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - directed scoreboard bench for inst_fetch_unit
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack;
    logic [31:0] im_rdata;
    logic [31:0] instruction;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        redirect;
    logic [1:0]  pc_mux_sel;
    logic        branch_taken;
    logic [31:0] ctl_pc;
    logic [15:0] imm;
    logic [25:0] jump_index;

    int checks = 0;
    int errors = 0;
    int lat = 0;
    int wait_cnt = 0;
    logic tb_drop = 1'b0;
    logic [63:0] sb[$];
    logic [31:0] ack_addrs[$];

    inst_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack), .im_rdata(im_rdata),
        .instruction(instruction), .inst_pc(inst_pc), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .redirect(redirect), .pc_mux_sel(pc_mux_sel),
        .branch_taken(branch_taken), .ctl_pc(ctl_pc), .imm(imm), .jump_index(jump_index)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: score the decoder side, play memory, then advance to the next falling edge.
    task automatic tick();
        logic eff;
        eff = redirect && ((pc_mux_sel == 2'b10) || ((pc_mux_sel == 2'b01) && branch_taken));
        if (inst_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("sb_has_item", 64'd0, 64'd1);
            end else begin
                check("sb_out", {inst_pc, instruction}, sb[0]);
                if (inst_ready || eff) void'(sb.pop_front());
            end
        end
        if (im_req === 1'b1) begin
            if (wait_cnt >= lat) begin
                im_ack   = 1'b1;
                im_rdata = mem_word(im_addr);
                ack_addrs.push_back(im_addr);
                if (!(tb_drop || eff)) sb.push_back({im_addr, mem_word(im_addr)});
                tb_drop  = 1'b0;
                wait_cnt = 0;
            end else begin
                im_ack   = 1'b0;
                im_rdata = 32'hBAD0_0000;
                wait_cnt++;
                if (eff) tb_drop = 1'b1;
            end
        end else begin
            im_ack   = 1'b0;
            im_rdata = 32'hBAD0_0000;
        end
        @(posedge clk);
        @(negedge clk);
        redirect = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; im_ack = 1'b0; im_rdata = 32'd0; inst_ready = 1'b1;
        redirect = 1'b0; pc_mux_sel = 2'b00; branch_taken = 1'b0;
        ctl_pc = 32'd0; imm = 16'd0; jump_index = 26'd0;
        repeat (2) @(negedge clk);
        check("rst_im_req", {63'd0, im_req}, 64'd0);
        check("rst_im_addr", {32'd0, im_addr}, 64'd0);
        check("rst_instruction", {32'd0, instruction}, 64'd0);
        check("rst_inst_pc", {32'd0, inst_pc}, 64'd0);
        check("rst_inst_valid", {63'd0, inst_valid}, 64'd0);

        // Sequential fetch with zero-latency memory
        rst_n = 1'b1;
        ack_addrs.delete();
        check("idle_no_req", {63'd0, im_req}, 64'd0);
        repeat (7) tick();
        check("seq_n_acks", 64'(ack_addrs.size()), 64'd3);
        for (int i = 0; i < 3 && i < ack_addrs.size(); i++)
            check("seq_addr", {32'd0, ack_addrs[i]}, 64'(4 * i));

        // Decoder stall while holding
        inst_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", {63'd0, inst_valid}, 64'd1);
            check("stall_no_req", {63'd0, im_req}, 64'd0);
            check("stall_pc", {32'd0, inst_pc}, 64'h0C);
            tick();
        end
        inst_ready = 1'b1;
        tick();
        check("after_stall_addr", {32'd0, im_addr}, 64'h10);
        check("after_stall_req", {63'd0, im_req}, 64'd1);

        // Jump while holding drops the held word
        tick();
        inst_ready = 1'b0;
        redirect = 1'b1; pc_mux_sel = 2'b10; ctl_pc = 32'h1000_0010; jump_index = 26'h000_0040;
        tick();
        inst_ready = 1'b1;
        check("jump_valid_low", {63'd0, inst_valid}, 64'd0);
        check("jump_addr", {32'd0, im_addr}, 64'h1000_0100);
        check("jump_sb_empty", 64'(sb.size()), 64'd0);

        // Taken branch while the request is outstanding
        lat = 3;
        redirect = 1'b1; pc_mux_sel = 2'b01; branch_taken = 1'b1; ctl_pc = 32'h20; imm = 16'hFFFC;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("drop_req", {63'd0, im_req}, 64'd1);
            check("drop_addr", {32'd0, im_addr}, 64'h1000_0100);
            check("drop_valid", {63'd0, inst_valid}, 64'd0);
            tick();
        end
        check("drop_old_acked", {32'd0, ack_addrs[$]}, 64'h1000_0100);
        check("branch_addr", {32'd0, im_addr}, 64'h14);
        check("branch_valid_low", {63'd0, inst_valid}, 64'd0);
        lat = 0;
        tick();
        tick();

        // Ignored redirects: branch not taken, reserved selector
        redirect = 1'b1; pc_mux_sel = 2'b01; branch_taken = 1'b0; ctl_pc = 32'h100; imm = 16'd5;
        tick();
        redirect = 1'b1; pc_mux_sel = 2'b11; ctl_pc = 32'h200; jump_index = 26'h123_4567;
        tick();
        check("ignored_addr", {32'd0, im_addr}, 64'h1C);

        // Jump coinciding with an ack lands on the top word; sequential fetch wraps
        redirect = 1'b1; pc_mux_sel = 2'b10; ctl_pc = 32'hF000_0000; jump_index = 26'h3FF_FFFF;
        tick();
        check("top_addr", {32'd0, im_addr}, 64'hFFFF_FFFC);
        check("top_sb_empty", 64'(sb.size()), 64'd0);
        tick();
        tick();
        check("wrap_addr", {32'd0, im_addr}, 64'h0);

        // Reset in the middle of a dropped request
        lat = 5;
        redirect = 1'b1; pc_mux_sel = 2'b01; branch_taken = 1'b1; ctl_pc = 32'h0; imm = 16'd1;
        tick();
        tick();
        rst_n = 1'b0;
        im_ack = 1'b0;
        #1;
        check("mid_rst_req", {63'd0, im_req}, 64'd0);
        check("mid_rst_addr", {32'd0, im_addr}, 64'd0);
        check("mid_rst_valid", {63'd0, inst_valid}, 64'd0);
        check("mid_rst_inst", {32'd0, instruction}, 64'd0);
        check("mid_rst_pc", {32'd0, inst_pc}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        tb_drop = 1'b0;
        wait_cnt = 0;
        lat = 0;
        tick();
        check("post_rst_req", {63'd0, im_req}, 64'd1);
        check("post_rst_addr", {32'd0, im_addr}, 64'd0);
        tick();
        tick();
        check("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
